shift_load_sequencer: RTL and testbench
=======================================

SHIFT_LOAD_SEQUENCER -- requirements
Module: shift_load_sequencer

Interface
REQ-001 Parameter LOAD_PERIOD, default 4, shifts per parallel load (legal 2..16; 4 = one 194 register, 8 = two cascaded).
REQ-002 clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 CR_n  in  1  reset, synchronous, active-low.
REQ-004 run  in  1  sequencing enable (low during blanking).
REQ-005 pix_cen  in  1  pixel-advance strobe, one clk wide, min spacing 2 clk.
REQ-006 data_valid  in  1  next parallel word is present on the shifter D inputs.
REQ-007 flip_in  in  1  horizontal flip attribute of the presented word.
REQ-008 data_ack  out  1  one-clk pulse; presented word consumed.
REQ-009 sr_S0, sr_S1  out  1 each  mode select to the shift-register bank.
REQ-010 sr_cp  out  1  step strobe to the bank's cen input, one clk high per step.
REQ-011 sr_CR_n  out  1  clear to the bank, active-low.
REQ-012 tap_sel  out  1  0 = take pixel from Q3 end, 1 = from Q0 end.
REQ-013 phase  out  4  current pixel index within the loaded word.
REQ-014 underrun  out  1  one-clk pulse; load due but data_valid low.
REQ-015 step_err  out  1  one-clk pulse; pix_cen dropped (spacing violation).

Function
REQ-016 States SHALL be IDLE, PRIME, RUN.
REQ-017 IDLE: {S1,S0}=00, sr_cp=0, sr_CR_n=0; run=1 -> PRIME next clk.
REQ-018 PRIME: sr_CR_n=1; on pix_cen with data_valid=1 -> load step, phase=0, -> RUN; pix_cen with data_valid=0 -> no step, no underrun, stay PRIME.
REQ-019 Every step (load or shift) SHALL appear one clk after the accepted pix_cen as sr_cp=1 with the mode bits already valid in that same clk; sr_cp returns to 0 the next clk.
REQ-020 Mode bits SHALL hold their last value between steps; they change only in the clk sr_cp rises.
REQ-021 Load step: {S1,S0}=11, data_ack=1 in the same clk as sr_cp, flip_in latched into tap_sel.
REQ-022 RUN, pix_cen with phase<LOAD_PERIOD-1: shift step, phase+1; tap_sel=0 -> {S1,S0}=01, tap_sel=1 -> {S1,S0}=10.
REQ-023 RUN, pix_cen with phase=LOAD_PERIOD-1 and data_valid=1: load step, phase wraps to 0.
REQ-024 RUN, pix_cen with phase=LOAD_PERIOD-1 and data_valid=0: underrun=1, sr_CR_n=0 for one clk, no sr_cp, phase=0, -> PRIME.
REQ-025 pix_cen arriving while sr_cp=1 SHALL be ignored and pulse step_err; state and phase unchanged.
REQ-026 run=0 in any state SHALL force IDLE next clk (sr_CR_n=0, sr_cp=0, phase=0), overriding a simultaneous pix_cen; no data_ack issued.
REQ-027 data_ack SHALL never pulse without a coincident load step.

Reset
REQ-028 CR_n=0 SHALL, on the next clk edge, set state IDLE, sr_cp=0, {S1,S0}=00, sr_CR_n=0, data_ack=0, tap_sel=0, phase=0, underrun=0, step_err=0; it overrides all other inputs, including mid-step.

Structure
REQ-029 Shared package SHALL hold the state enum and mode constants SR_HOLD=00, SR_SHR=01, SR_SHL=10, SR_LOAD=11.
REQ-030 Phase counter with wrap detect SHALL be a sub-module, shift_phase_counter.

Verification
REQ-031 Reset, run=1, data_valid=1, flip_in=0, pix_cen every 4 clk, LOAD_PERIOD=4 -> steps 11,01,01,01,11...; data_ack every 4th step; phase 0,1,2,3,0.
REQ-032 Same with flip_in=1 -> shifts use 10, tap_sel=1 from first load.
REQ-033 data_valid=0 at phase 3 pix_cen -> underrun pulse, sr_CR_n low 1 clk, PRIME; restore data_valid -> next pix_cen loads, phase=0.
REQ-034 pix_cen on 2 consecutive clks -> second dropped, step_err=1, one sr_cp only.
REQ-035 run falls coincident with pix_cen at phase 2 -> no step, IDLE, sr_CR_n=0 next clk.
REQ-036 CR_n low in the clk sr_cp=1 -> all outputs at reset values next clk.

Source files
------------

// File: rtl/shift_load_sequencer_pkg.sv
// shift_load_sequencer_pkg: sequencer state encoding and shift-register bank mode constants
package shift_load_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHR  = 2'b01;
  localparam logic [1:0] SR_SHL  = 2'b10;
  localparam logic [1:0] SR_LOAD = 2'b11;
endpackage

// File: rtl/shift_phase_counter.sv
// shift_phase_counter: pixel index within the loaded word, flags the last pixel before a reload
// Ports: clk, CR_n (sync active-low reset), i_clr (force 0), i_inc (advance), o_phase, o_wrap (phase is LOAD_PERIOD-1)
module shift_phase_counter
  import shift_load_sequencer_pkg::*;
#(
  parameter int LOAD_PERIOD = 4
) (
  input  logic       clk,
  input  logic       CR_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_phase,
  output logic       o_wrap
);
  logic [3:0] r_phase;
  always_ff @(posedge clk) begin
    if (!CR_n || i_clr) r_phase <= 4'd0;
    else if (i_inc) r_phase <= r_phase + 4'd1;
  end
  assign o_phase = r_phase;
  assign o_wrap  = r_phase == 4'(LOAD_PERIOD - 1);
endmodule

// File: rtl/shift_load_sequencer.sv
// shift_load_sequencer: drives load/shift steps of a 194-style shift-register bank from a pixel strobe
// Ports: clk, CR_n (sync active-low reset), run, pix_cen, data_valid, flip_in in;
//        data_ack, sr_S0, sr_S1, sr_cp, sr_CR_n, tap_sel, phase[3:0], underrun, step_err out (all registered)
module shift_load_sequencer
  import shift_load_sequencer_pkg::*;
#(
  parameter int LOAD_PERIOD = 4
) (
  input  logic       clk,
  input  logic       CR_n,
  input  logic       run,
  input  logic       pix_cen,
  input  logic       data_valid,
  input  logic       flip_in,
  output logic       data_ack,
  output logic       sr_S0,
  output logic       sr_S1,
  output logic       sr_cp,
  output logic       sr_CR_n,
  output logic       tap_sel,
  output logic [3:0] phase,
  output logic       underrun,
  output logic       step_err
);
  state_t     r_state;
  logic [1:0] r_mode;
  logic       r_cp, r_cr_n, r_ack, r_tap, r_under, r_err;
  logic [3:0] w_phase;
  logic       w_wrap, w_acc, w_drop, w_load, w_shift, w_under, w_clr;
  // a strobe landing while the previous step is still on sr_cp violates spacing and is dropped
  assign w_acc   = run && pix_cen && !r_cp;
  assign w_drop  = run && pix_cen && r_cp;
  assign w_load  = w_acc && data_valid && (r_state == PRIME || (r_state == RUN && w_wrap));
  assign w_shift = w_acc && r_state == RUN && !w_wrap;
  assign w_under = w_acc && r_state == RUN && w_wrap && !data_valid;
  assign w_clr   = !run || w_load || w_under;
  shift_phase_counter #(.LOAD_PERIOD(LOAD_PERIOD)) u_phase (
    .clk    (clk),
    .CR_n   (CR_n),
    .i_clr  (w_clr),
    .i_inc  (w_shift),
    .o_phase(w_phase),
    .o_wrap (w_wrap)
  );
  always_ff @(posedge clk) begin
    if (!CR_n) begin
      r_state <= IDLE;
      r_mode  <= SR_HOLD;
      r_cp    <= 1'b0;
      r_cr_n  <= 1'b0;
      r_ack   <= 1'b0;
      r_tap   <= 1'b0;
      r_under <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_cp    <= w_load || w_shift;
      r_ack   <= w_load;
      r_under <= w_under;
      r_err   <= w_drop;
      r_cr_n  <= run && !w_under;
      r_state <= !run ? IDLE : r_state == IDLE ? PRIME : w_load ? RUN : w_under ? PRIME : r_state;
      if (!run) r_mode <= SR_HOLD;
      else if (w_load) r_mode <= SR_LOAD;
      else if (w_shift) r_mode <= r_tap ? SR_SHL : SR_SHR;
      if (w_load) r_tap <= flip_in;
    end
  end
  assign sr_S0    = r_mode[0];
  assign sr_S1    = r_mode[1];
  assign sr_cp    = r_cp;
  assign sr_CR_n  = r_cr_n;
  assign data_ack = r_ack;
  assign tap_sel  = r_tap;
  assign phase    = w_phase;
  assign underrun = r_under;
  assign step_err = r_err;
endmodule

// File: tb/tb_shift_load_sequencer.sv
// tb_shift_load_sequencer: directed vector table plus a hand-paced strobe sequence for shift_load_sequencer
module tb_shift_load_sequencer;
  logic       clk = 1'b0;
  logic       CR_n = 1'b0, run = 1'b0, pix_cen = 1'b0, data_valid = 1'b0, flip_in = 1'b0;
  logic       data_ack, sr_S0, sr_S1, sr_cp, sr_CR_n, tap_sel, underrun, step_err;
  logic [3:0] phase;
  int         n_vec = 0, n_bad = 0;
  typedef struct {
    logic        crn, rn, pc, dv, fl;
    logic [11:0] exp;
  } vec_t;
  vec_t tv[34];
  always #5 clk = ~clk;
  shift_load_sequencer #(.LOAD_PERIOD(4)) dut (
    .clk       (clk),
    .CR_n      (CR_n),
    .run       (run),
    .pix_cen   (pix_cen),
    .data_valid(data_valid),
    .flip_in   (flip_in),
    .data_ack  (data_ack),
    .sr_S0     (sr_S0),
    .sr_S1     (sr_S1),
    .sr_cp     (sr_cp),
    .sr_CR_n   (sr_CR_n),
    .tap_sel   (tap_sel),
    .phase     (phase),
    .underrun  (underrun),
    .step_err  (step_err)
  );
  function automatic vec_t v(logic crn, logic rn, logic pc, logic dv, logic fl, logic cp, logic [1:0] m,
                             logic srcr, logic ack, logic tap, logic [3:0] ph, logic un, logic er);
    vec_t r;
    r.crn = crn; r.rn = rn; r.pc = pc; r.dv = dv; r.fl = fl;
    r.exp = {cp, m, srcr, ack, tap, ph, un, er};
    return r;
  endfunction
  task automatic drive(input logic crn, input logic rn, input logic pc, input logic dv, input logic fl);
    CR_n = crn; run = rn; pix_cen = pc; data_valid = dv; flip_in = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {sr_cp, sr_S1, sr_S0, sr_CR_n, data_ack, tap_sel, phase, underrun, step_err};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cp,S1S0,CR_n,ack,tap,phase,un,err}=%b required %b", name, got, exp);
    end
  endtask
  initial begin
    tv[0]  = v(0,0,0,0,0, 0,2'b00,0,0,0,0,0,0);
    tv[1]  = v(1,1,0,1,0, 0,2'b00,1,0,0,0,0,0);
    tv[2]  = v(1,1,1,1,0, 1,2'b11,1,1,0,0,0,0);
    tv[3]  = v(1,1,0,1,0, 0,2'b11,1,0,0,0,0,0);
    tv[4]  = v(1,1,1,1,0, 1,2'b01,1,0,0,1,0,0);
    tv[5]  = v(1,1,0,1,0, 0,2'b01,1,0,0,1,0,0);
    tv[6]  = v(1,1,1,1,0, 1,2'b01,1,0,0,2,0,0);
    tv[7]  = v(1,1,0,1,0, 0,2'b01,1,0,0,2,0,0);
    tv[8]  = v(1,1,1,1,0, 1,2'b01,1,0,0,3,0,0);
    tv[9]  = v(1,1,0,1,0, 0,2'b01,1,0,0,3,0,0);
    tv[10] = v(1,1,1,1,1, 1,2'b11,1,1,1,0,0,0);
    tv[11] = v(1,1,0,1,0, 0,2'b11,1,0,1,0,0,0);
    tv[12] = v(1,1,1,1,0, 1,2'b10,1,0,1,1,0,0);
    tv[13] = v(1,1,0,1,0, 0,2'b10,1,0,1,1,0,0);
    tv[14] = v(1,1,1,1,0, 1,2'b10,1,0,1,2,0,0);
    tv[15] = v(1,1,0,1,0, 0,2'b10,1,0,1,2,0,0);
    tv[16] = v(1,1,1,1,0, 1,2'b10,1,0,1,3,0,0);
    tv[17] = v(1,1,0,1,0, 0,2'b10,1,0,1,3,0,0);
    tv[18] = v(1,1,1,0,0, 0,2'b10,0,0,1,0,1,0);
    tv[19] = v(1,1,0,0,0, 0,2'b10,1,0,1,0,0,0);
    tv[20] = v(1,1,1,0,0, 0,2'b10,1,0,1,0,0,0);
    tv[21] = v(1,1,0,1,0, 0,2'b10,1,0,1,0,0,0);
    tv[22] = v(1,1,1,1,0, 1,2'b11,1,1,0,0,0,0);
    tv[23] = v(1,1,1,1,0, 0,2'b11,1,0,0,0,0,1);
    tv[24] = v(1,1,0,1,0, 0,2'b11,1,0,0,0,0,0);
    tv[25] = v(1,1,1,1,0, 1,2'b01,1,0,0,1,0,0);
    tv[26] = v(1,1,0,1,0, 0,2'b01,1,0,0,1,0,0);
    tv[27] = v(1,1,1,1,0, 1,2'b01,1,0,0,2,0,0);
    tv[28] = v(1,1,0,1,0, 0,2'b01,1,0,0,2,0,0);
    tv[29] = v(1,0,1,1,0, 0,2'b00,0,0,0,0,0,0);
    tv[30] = v(1,1,0,1,0, 0,2'b00,1,0,0,0,0,0);
    tv[31] = v(1,1,1,1,1, 1,2'b11,1,1,1,0,0,0);
    tv[32] = v(0,1,1,1,0, 0,2'b00,0,0,0,0,0,0);
    tv[33] = v(1,1,0,1,0, 0,2'b00,1,0,0,0,0,0);
    for (int i = 0; i < 34; i++) begin
      drive(tv[i].crn, tv[i].rn, tv[i].pc, tv[i].dv, tv[i].fl);
      chk($sformatf("tv%0d", i), tv[i].exp);
    end
    for (int k = 0; k < 9; k++) begin
      logic [1:0] m;
      logic [3:0] ph;
      logic       ld;
      ld = (k % 4) == 0;
      m  = ld ? 2'b11 : 2'b01;
      ph = 4'(k % 4);
      drive(1, 1, 1, 1, 0);
      chk($sformatf("slow_step%0d", k), {1'b1, m, 1'b1, ld, 1'b0, ph, 2'b00});
      for (int j = 0; j < 3; j++) begin
        drive(1, 1, 0, 1, 0);
        chk($sformatf("slow_hold%0d_%0d", k, j), {1'b0, m, 1'b1, 1'b0, 1'b0, ph, 2'b00});
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
